seg7_scan_display: RTL and testbench
====================================

// Module: seg7_scan_display
// PURPOSE
//  Downstream consumer of the 8-bit up/down counter output (C_CNT).
//  Time-multiplexes a DIGITS-wide hex value onto a common-anode 7-segment display.
//  Each full scan of the digits latches a tear-free snapshot of VALUE.
//  Provides a refresh prescaler and optional leading-zero blanking.
//  Outputs drive board pins directly.
// PARAMETERS
//  DIGITS       2     number of hex digits; VALUE width = 4*DIGITS (>=1)
//  REFRESH_DIV  1000  CLK cycles each digit is lit (>=1; 1 = new digit every cycle)
//  ACTIVE_LOW   1     1: AN/SEG active-low (lit = 0); 0: active-high
// PORTS
//  CLK       in   1         system clock, all logic on posedge
//  RST       in   1         synchronous reset, active-high
//  EN        in   1         1 = scan running; 0 = display dark, scan state frozen
//  BLANK_LZ  in   1         1 = blank leading zero digits
//  VALUE     in   4*DIGITS  value to show; nibble i -> digit i (digit 0 = LSD)
//  AN        out  DIGITS    digit enables, one-hot lit (polarity per ACTIVE_LOW)
//  SEG       out  7         segments {g,f,e,d,c,b,a} (polarity per ACTIVE_LOW)
// BEHAVIOUR
//  - Reset (RST=1 at posedge):
//    - pdiv=0, idx=0, snap=0.
//    - AN=all-off and SEG=all-off (7'h7F / {DIGITS{1}} when ACTIVE_LOW).
//    - Reset wins over EN and takes effect mid-scan.
//  - Prescaler pdiv runs 0..REFRESH_DIV-1 while EN=1.
//    - tick = EN && pdiv==REFRESH_DIV-1; pdiv wraps to 0 on tick.
//  - idx advances by 1 on tick; at DIGITS-1 it wraps to 0.
//  - Snapshot: on a tick with idx==DIGITS-1, snap<=VALUE on the same edge as the wrap to 0.
//    - VALUE changes between boundaries are not visible.
//  - Outputs are registered from (idx, snap): AN/SEG reflect the new idx 1 cycle after the tick.
//    - Displayed VALUE latency: 1 cycle after the next scan boundary.
//  - Decode uses the standard hex table (active-high gfedcba):
//    - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//    - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
//    - ACTIVE_LOW inverts both SEG and AN.
//  - Blanking: with BLANK_LZ=1, digit i>0 is blanked when nibbles i..DIGITS-1 of snap are all 0.
//    - A blanked digit has AN all-off and SEG all-off.
//    - Digit 0 is never blanked, so value 0 shows "0".
//  - EN=0:
//    - Next edge: AN and SEG go all-off; pdiv, idx and snap hold.
//    - On re-assert, the scan resumes on the held digit with the held pdiv count.
//  - Exactly one AN bit is lit at any time while enabled and not blanked; no ghosting cycle.
// STRUCTURE
//  - Shared package seg7_defs:
//    - the 16-entry hex->segment table as localparams;
//    - SEG_OFF/AN_OFF constants;
//    - the segment bit-order definition.
//  - One sub-module, hex_to_seg7: combinational 4-bit -> 7-bit active-high decoder.
//  - Top module holds the prescaler, idx, snap, blank logic, polarity and output registers.
// TESTING (DIGITS=2, REFRESH_DIV=4, ACTIVE_LOW=1 unless stated)
//  1. RST=1 for 3 cycles with EN=1 and VALUE=8'hFF -> AN=2'b11, SEG=7'h7F each cycle; then first scan shows 00.
//  2. VALUE=8'h3A held two scans -> second scan: AN=2'b10, SEG=7'h08 for 4 cycles, then AN=2'b01, SEG=7'h30 for 4 cycles.
//  3. VALUE 8'h3A->8'h55 while digit 0 is lit -> digit 1 still shows 7'h30; new 7'h12/7'h12 appears only after the scan boundary.
//  4. BLANK_LZ=1:
//     - VALUE=8'h05 -> digit-1 slot AN=2'b11, SEG=7'h7F; digit 0 SEG=7'h12.
//     - VALUE=8'h00 -> digit 0 shows 7'h40.
//  5. EN=0 for 10 cycles mid digit 1 -> AN=2'b11 next edge; on re-assert digit 1 completes its remaining cycles.
//  6. Chain with counter_top counting down from 8'h01 -> display shows 01, 00, FF across successive snapshots.

Source files
------------

// File: rtl/seg7_scan_display_pkg.sv
// Purpose: shared constants for the 7-segment scan display (hex table, off levels, bit order).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seg7_defs;

    // Segment bit order on the 7-bit bus, MSB first: {g,f,e,d,c,b,a}.
    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg7_t;

    // Active-high hex glyphs (1 = segment lit).
    localparam logic [6:0] HEX_0 = 7'h3F;
    localparam logic [6:0] HEX_1 = 7'h06;
    localparam logic [6:0] HEX_2 = 7'h5B;
    localparam logic [6:0] HEX_3 = 7'h4F;
    localparam logic [6:0] HEX_4 = 7'h66;
    localparam logic [6:0] HEX_5 = 7'h6D;
    localparam logic [6:0] HEX_6 = 7'h7D;
    localparam logic [6:0] HEX_7 = 7'h07;
    localparam logic [6:0] HEX_8 = 7'h7F;
    localparam logic [6:0] HEX_9 = 7'h6F;
    localparam logic [6:0] HEX_A = 7'h77;
    localparam logic [6:0] HEX_B = 7'h7C;
    localparam logic [6:0] HEX_C = 7'h39;
    localparam logic [6:0] HEX_D = 7'h5E;
    localparam logic [6:0] HEX_E = 7'h79;
    localparam logic [6:0] HEX_F = 7'h71;

    // Dark levels in the active-high domain; pin polarity is applied in the top.
    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic       AN_OFF  = 1'b0;

endpackage

// File: rtl/hex_to_seg7.sv
// Purpose: 4-bit nibble to active-high {g,f,e,d,c,b,a} segment pattern.
// Latency: combinational, 0 cycles.
// Backpressure: none.
// Ports: nib_i (hex nibble), seg_o (active-high segments).
module hex_to_seg7
    import seg7_defs::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    seg7_t seg;

    always_comb begin
        seg = seg7_t'(SEG_OFF);
        unique case (nib_i)
            4'h0: seg = seg7_t'(HEX_0);
            4'h1: seg = seg7_t'(HEX_1);
            4'h2: seg = seg7_t'(HEX_2);
            4'h3: seg = seg7_t'(HEX_3);
            4'h4: seg = seg7_t'(HEX_4);
            4'h5: seg = seg7_t'(HEX_5);
            4'h6: seg = seg7_t'(HEX_6);
            4'h7: seg = seg7_t'(HEX_7);
            4'h8: seg = seg7_t'(HEX_8);
            4'h9: seg = seg7_t'(HEX_9);
            4'hA: seg = seg7_t'(HEX_A);
            4'hB: seg = seg7_t'(HEX_B);
            4'hC: seg = seg7_t'(HEX_C);
            4'hD: seg = seg7_t'(HEX_D);
            4'hE: seg = seg7_t'(HEX_E);
            4'hF: seg = seg7_t'(HEX_F);
            default: seg = seg7_t'(SEG_OFF);
        endcase
    end

    assign seg_o = seg;

endmodule

// File: rtl/seg7_scan_display.sv
// Purpose: time-multiplexed hex display driver with per-scan snapshot and leading-zero blanking.
// Latency: AN/SEG follow the scan index 1 cycle after each tick; new VALUE shows 1 cycle after the next scan boundary.
// Backpressure: none; en_i=0 darkens the pins and freezes prescaler, index and snapshot.
// Ports: clk_i, rst_i (sync, active-high), en_i, blank_lz_i, value_i[4*DIGITS], an_o[DIGITS], seg_o[7].
module seg7_scan_display
    import seg7_defs::*;
#(
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 1000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  blank_lz_i,
    input  logic [4*DIGITS-1:0]   value_i,
    output logic [DIGITS-1:0]     an_o,
    output logic [6:0]            seg_o
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PDIV_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    // Dark levels as they appear on the pins.
    localparam logic [DIGITS-1:0] AN_PIN_OFF  = ACTIVE_LOW ? ~{DIGITS{AN_OFF}} : {DIGITS{AN_OFF}};
    localparam logic [6:0]        SEG_PIN_OFF = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

    logic [PW-1:0]       pdiv_q, pdiv_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;

    logic                tick;
    logic [3:0]          nib;
    logic [6:0]          dec_seg;
    logic                upper_zero;
    logic                blank;
    logic [DIGITS-1:0]   an_hi;
    logic [6:0]          seg_hi;

    assign tick = en_i && (pdiv_q == PDIV_LAST);

    // Prescaler, scan index and snapshot; snapshot refreshes only on the wrap so a scan never tears.
    always_comb begin
        pdiv_d = pdiv_q;
        idx_d  = idx_q;
        snap_d = snap_q;
        if (tick) begin
            pdiv_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d  = '0;
                snap_d = value_i;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else if (en_i) begin
            pdiv_d = pdiv_q + PW'(1);
        end
    end

    // Nibble select, and "this digit and everything above it is zero" for blanking.
    always_comb begin
        nib        = 4'h0;
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx_q) begin
                nib = snap_q[4*i +: 4];
            end
            if ((IW'(i) >= idx_q) && (snap_q[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    hex_to_seg7 u_dec (
        .nib_i (nib),
        .seg_o (dec_seg)
    );

    // Digit 0 is never blanked so an all-zero value still shows "0".
    assign blank = blank_lz_i && (idx_q != '0) && upper_zero;

    always_comb begin
        an_hi  = {DIGITS{AN_OFF}};
        seg_hi = SEG_OFF;
        if (en_i && !blank) begin
            for (int i = 0; i < DIGITS; i++) begin
                an_hi[i] = (IW'(i) == idx_q);
            end
            seg_hi = dec_seg;
        end
        an_d  = ACTIVE_LOW ? ~an_hi  : an_hi;
        seg_d = ACTIVE_LOW ? ~seg_hi : seg_hi;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pdiv_q <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            an_q   <= AN_PIN_OFF;
            seg_q  <= SEG_PIN_OFF;
        end else begin
            pdiv_q <= pdiv_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Purpose: self-checking bench for seg7_scan_display (DIGITS=2, REFRESH_DIV=4, ACTIVE_LOW=1).
// Latency: expected pin values are queued per edge and popped half a cycle later.
// Backpressure: n/a.
module tb_seg7_scan_display;

    localparam int DIGITS = 2;
    localparam int RDIV   = 4;
    localparam logic [8:0] OFF = {2'b11, 7'h7F};
    localparam logic [6:0] HEX_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       rst, en, blz;
    logic [7:0] value;
    logic [1:0] an;
    logic [6:0] seg;

    always #5 clk = ~clk;

    seg7_scan_display #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (RDIV),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .blank_lz_i (blz),
        .value_i    (value),
        .an_o       (an),
        .seg_o      (seg)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [8:0] q_exp [$];
    int         m_pdiv = 0;
    int         m_idx  = 0;
    logic [7:0] m_snap = 8'h00;

    // Pin pattern {AN,SEG} for the digit the reference scan is currently on.
    function automatic logic [8:0] model_disp();
        logic [3:0] n;
        logic [1:0] a_hi;
        logic [6:0] s_hi;
        n    = (m_idx == 0) ? m_snap[3:0] : m_snap[7:4];
        a_hi = (m_idx == 0) ? 2'b01 : 2'b10;
        s_hi = HEX_TAB[n];
        if (blz && m_idx == 1 && m_snap[7:4] == 4'h0) begin
            a_hi = 2'b00;
            s_hi = 7'h00;
        end
        return {~a_hi, ~s_hi};
    endfunction

    // Predict the value the next edge registers, queue it, then advance to the sampling point.
    task automatic step();
        logic [8:0] e;
        if (rst) begin
            e      = OFF;
            m_pdiv = 0;
            m_idx  = 0;
            m_snap = 8'h00;
        end else begin
            e = en ? model_disp() : OFF;
            if (en) begin
                if (m_pdiv == RDIV - 1) begin
                    m_pdiv = 0;
                    if (m_idx == DIGITS - 1) begin
                        m_idx  = 0;
                        m_snap = value;
                    end else begin
                        m_idx++;
                    end
                end else begin
                    m_pdiv++;
                end
            end
        end
        q_exp.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance (unchecked) until the next edge starts a fresh scan on digit 0.
    task automatic align();
        logic [8:0] e;
        for (int k = 0; k < 2 * DIGITS * RDIV; k++) begin
            if (m_pdiv == 0 && m_idx == 0) break;
            step();
            e = q_exp.pop_front();
        end
    endtask

    task automatic test_reset();
        logic [8:0] e, lit;
        rst = 1'b1; en = 1'b1; blz = 1'b0; value = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            e = q_exp.pop_front();
            tests_run++;
            if ({an, seg} !== e) begin
                tests_failed++;
                $display("FAIL reset c%0d: got an=%b seg=%h, want an=%b seg=%h", i, an, seg, e[8:7], e[6:0]);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            e   = q_exp.pop_front();
            lit = (i < 4) ? {2'b10, 7'h40} : {2'b01, 7'h40};
            tests_run++;
            if ({an, seg} !== e || {an, seg} !== lit) begin
                tests_failed++;
                $display("FAIL first_scan c%0d: got an=%b seg=%h, want an=%b seg=%h", i, an, seg, lit[8:7], lit[6:0]);
            end
        end
    endtask

    task automatic test_value();
        logic [8:0] e, lit;
        value = 8'h3A;
        align();
        for (int i = 0; i < 16; i++) begin
            step();
            e   = q_exp.pop_front();
            lit = (i < 12) ? {2'b10, 7'h08} : {2'b01, 7'h30};
            tests_run++;
            if ({an, seg} !== e || (i >= 8 && {an, seg} !== lit)) begin
                tests_failed++;
                $display("FAIL value_3A c%0d: got an=%b seg=%h, want an=%b seg=%h", i, an, seg, e[8:7], e[6:0]);
            end
        end
    endtask

    task automatic test_tear();
        logic [8:0] e, lit;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) value = 8'h55;
            step();
            e = q_exp.pop_front();
            if (i < 4)       lit = {2'b10, 7'h08};
            else if (i < 8)  lit = {2'b01, 7'h30};
            else if (i < 12) lit = {2'b10, 7'h12};
            else             lit = {2'b01, 7'h12};
            tests_run++;
            if ({an, seg} !== e || {an, seg} !== lit) begin
                tests_failed++;
                $display("FAIL tear c%0d: got an=%b seg=%h, want an=%b seg=%h", i, an, seg, lit[8:7], lit[6:0]);
            end
        end
    endtask

    task automatic test_blank();
        logic [8:0] e, lit;
        logic [7:0] vals [3] = '{8'h05, 8'h00, 8'h50};
        blz = 1'b1;
        for (int v = 0; v < 3; v++) begin
            value = vals[v];
            align();
            for (int i = 0; i < 16; i++) begin
                step();
                e = q_exp.pop_front();
                if (v == 0)      lit = (i < 12) ? {2'b10, 7'h12} : OFF;
                else if (v == 1) lit = (i < 12) ? {2'b10, 7'h40} : OFF;
                else             lit = (i < 12) ? {2'b10, 7'h40} : {2'b01, 7'h12};
                tests_run++;
                if ({an, seg} !== e || (i >= 8 && {an, seg} !== lit)) begin
                    tests_failed++;
                    $display("FAIL blank_%h c%0d: got an=%b seg=%h, want an=%b seg=%h", vals[v], i, an, seg, e[8:7], e[6:0]);
                end
            end
        end
        blz = 1'b0;
    endtask

    task automatic test_enable();
        logic [8:0] e, lit;
        value = 8'h3A;
        align();
        for (int i = 0; i < 27; i++) begin
            if (i == 14) en = 1'b0;
            if (i == 24) en = 1'b1;
            step();
            e = q_exp.pop_front();
            if (i >= 14 && i < 24) lit = OFF;
            else if (i < 26)       lit = {2'b01, 7'h30};
            else                   lit = {2'b10, 7'h08};
            tests_run++;
            if ({an, seg} !== e || (i >= 14 && {an, seg} !== lit)) begin
                tests_failed++;
                $display("FAIL enable c%0d: got an=%b seg=%h, want an=%b seg=%h", i, an, seg, e[8:7], e[6:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] e, lit;
        align();
        for (int i = 0; i < 14; i++) begin
            rst = (i == 5);
            step();
            e = q_exp.pop_front();
            if (i == 5)      lit = OFF;
            else if (i < 10) lit = {2'b10, 7'h40};
            else             lit = {2'b01, 7'h40};
            tests_run++;
            if ({an, seg} !== e || (i >= 5 && {an, seg} !== lit)) begin
                tests_failed++;
                $display("FAIL reset_mid c%0d: got an=%b seg=%h, want an=%b seg=%h", i, an, seg, e[8:7], e[6:0]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_chain();
        logic [8:0] e, lit;
        logic [6:0] want [3] = '{7'h79, 7'h40, 7'h0E};
        logic [6:0] want_hi [3] = '{7'h40, 7'h40, 7'h0E};
        value = 8'h01;
        align();
        for (int i = 0; i < 8; i++) begin
            step();
            e = q_exp.pop_front();
        end
        for (int s = 0; s < 3; s++) begin
            value = value - 8'h01;
            for (int i = 0; i < 8; i++) begin
                step();
                e   = q_exp.pop_front();
                lit = (i < 4) ? {2'b10, want[s]} : {2'b01, want_hi[s]};
                tests_run++;
                if ({an, seg} !== e || {an, seg} !== lit) begin
                    tests_failed++;
                    $display("FAIL chain s%0d c%0d: got an=%b seg=%h, want an=%b seg=%h", s, i, an, seg, lit[8:7], lit[6:0]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] e;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) blz = ~blz;
            if ($urandom_range(0, 5) == 0) value = 8'($urandom_range(0, 255));
            step();
            e = q_exp.pop_front();
            tests_run++;
            if ({an, seg} !== e) begin
                tests_failed++;
                $display("FAIL random c%0d: got an=%b seg=%h, want an=%b seg=%h", i, an, seg, e[8:7], e[6:0]);
            end
        end
        rst = 1'b0;
        en  = 1'b1;
        blz = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; blz = 1'b0; value = 8'hFF;
        test_reset();
        test_value();
        test_tear();
        test_blank();
        test_enable();
        test_reset_mid();
        test_chain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
